hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core; sits beside the ID stage and consumes the decoder's opcode/rd/rs1/rs2 fields.
- Tracks in-flight destination registers (EX, MEM, WB), detects RAW hazards, and drives per-stage register enables and flushes.
- Freezes the pipe on data-memory wait and bubbles on branch/jump redirect.
- Keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count performance counters.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  7  opcode from decoder
- id_rd  in  5  rd from decoder
- id_rs1  in  5  rs1 from decoder
- id_rs2  in  5  rs2 from decoder
- ex_redirect  in  1  branch taken / JAL / JALR resolved in EX
- mem_ready  in  1  data memory completes this cycle (0 = wait)
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- id_ex_en  out  1  ID/EX register enable
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_en  out  1  MEM/WB register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load NOP (bubble) into ID/EX
- stall_count  out  CNT_W  cycles with hazard or memory stall, saturating
- flush_count  out  CNT_W  redirect events, saturating

Behaviour:
- Opcode classes:
  - R (0110011), S (0100011) and B (1100011) read rs1 and rs2.
  - I-ALU (0010011), LOAD (0000011) and JALR (1100111) read rs1 only.
  - LUI, AUIPC and JAL read nothing.
  - R, I-ALU, LOAD, JAL, JALR, LUI and AUIPC write rd.
  - Unknown opcodes read and write nothing.
- x0 is never a hazard source. A read of x0, or a write with rd = 0, is ignored.
- Scoreboard: three registered slots (ex, mem, wb), each holding {valid, rd, is_load}.
  - Shifts ID→EX→MEM→WB when the corresponding enable is 1.
  - The ex slot loads 0 when id_ex_flush = 1.
- Outputs are combinational from the current FSM state and inputs. Priority, highest first:
  1. mem_ready = 0: all enables 0, both flushes 0, state → MEM_WAIT.
  2. ex_redirect = 1: all enables 1, if_id_flush = 1, id_ex_flush = 1, flush_count += 1, any hazard ignored, state → RUN.
  3. Hazard (see Optional Feature): pc_en = 0, if_id_en = 0, id_ex_en = 1 with id_ex_flush = 1, ex_mem_en = 1, mem_wb_en = 1, state → HAZ_STALL.
  4. Otherwise: all enables 1, no flush, state → RUN.
- FSM states: RUN, HAZ_STALL, MEM_WAIT.
  - State is informational, used for counters and debug; each cycle re-evaluates the priority list.
  - Leaving MEM_WAIT takes effect in the cycle mem_ready returns high.
- stall_count increments in every cycle with priority 1 or 3. Both counters saturate at all-ones and never wrap.
- Reset (asynchronous, any cycle, including mid-stall): scoreboard valids = 0, state = RUN, counters = 0.
  - Outputs during and immediately after reset: enables 1, flushes 0.
  - Reset never leaves a partial stall or flush pending.
- id_valid = 0 means no hazard is generated; the scoreboard still shifts, carrying an invalid entry.
- A simultaneous load-use hazard and redirect resolves as a redirect: the dependent instruction is flushed anyway.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined: the datapath forwards from EX/MEM and MEM/WB.
  - The only hazard is load-use: ex slot valid, is_load = 1, and rd matches a read source. This costs a 1-cycle stall.
  - Block additionally drives fwd_a_sel[1:0] and fwd_b_sel[1:0] for operands rs1 and rs2: 0 = regfile, 1 = MEM/WB, 2 = EX/MEM.
  - The younger (EX/MEM) match wins.
- Undefined: no forwarding ports.
  - A hazard is any match of a read source against a valid ex, mem or wb slot.
  - The register file is not write-through, so the stall lasts up to 3 cycles.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - the FSM state enum;
  - the fwd_sel encoding.
- Sub-module hazard_scoreboard: the three-slot rd shift register plus match logic, returning a per-source match vector.

Test Plan:
- LW x5,0(x1) then ADD x6,x5,x2, with HAZARD_FWD_EN defined → exactly 1 cycle of pc_en = 0 and id_ex_flush = 1; then fwd_a_sel = 1 for the ADD in EX.
- ADDI x3,x0,1 then SUB x4,x3,x3, with HAZARD_FWD_EN defined → no stall, fwd_a_sel = fwd_b_sel = 2. Without the macro → 3 stall cycles, stall_count = 3.
- ADDI x0,x0,5 then ADD x7,x0,x0 → no stall in either build.
- ex_redirect = 1 in the same cycle as a load-use hazard → if_id_flush = id_ex_flush = 1, pc_en = 1, flush_count = 1, no stall.
- mem_ready held 0 for 4 cycles during a hazard → all enables 0 for those 4 cycles; the hazard stall resumes after; stall_count reflects the total.
- reset_n asserted mid HAZ_STALL → immediately enables = 1, counters = 0, scoreboard empty. Drive 2^CNT_W + 5 stall cycles → stall_count holds at all-ones.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared definitions for the 5-stage core's sequencing logic.
//   - RV32I major opcode constants
//   - decoder class helpers: which register fields an opcode reads or writes
//   - pipeline controller state enum and forwarding-mux select encoding
// Optional build macro used by the consumers of this package: HAZARD_FWD_EN.
package riscv_pipe_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HAZ_STALL = 2'd1,
        ST_MEM_WAIT  = 2'd2
    } pipe_state_e;

    typedef enum logic [1:0] {
        FWD_RF     = 2'd0,
        FWD_MEM_WB = 2'd1,
        FWD_EX_MEM = 2'd2
    } fwd_sel_e;

    function automatic logic reads_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH, OP_IMM, OP_LOAD, OP_JALR: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: three-slot shift register of in-flight destination
// registers (ex, mem, wb) plus source-match logic for the instruction in ID.
//   clk, reset_n            clock, async active-low reset (clears all valids)
//   ex_en/mem_en/wb_en      shift enables for the ex, mem and wb slots
//   ex_flush                ex slot loads an empty entry instead of ID
//   id_wr, id_rd            ID instruction writes a non-x0 register, and which
//   rs1, rs2                ID read sources, already forced to 0 when not read
//   match_a, match_b        per-source hazard match, bit order {wb, mem, ex}
// With HAZARD_FWD_EN defined:
//   id_load                 ID instruction is a load
//   ex_match_a, ex_match_b  sources of the instruction in EX vs {wb, mem}
//   and only a load in the ex slot counts as a hazard match.
module hazard_scoreboard
    import riscv_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ex_en,
    input  logic       mem_en,
    input  logic       wb_en,
    input  logic       ex_flush,
    input  logic       id_wr,
    input  logic [4:0] id_rd,
`ifdef HAZARD_FWD_EN
    input  logic       id_load,
    output logic [1:0] ex_match_a,
    output logic [1:0] ex_match_b,
`endif
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic [2:0] match_a,
    output logic [2:0] match_b
);

    // index 0 = ex, 1 = mem, 2 = wb
    logic [2:0]      vld;
    logic [2:0][4:0] rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld  <= '0;
            rd_q <= '0;
        end else begin
            if (wb_en) begin
                vld[2]  <= vld[1];
                rd_q[2] <= rd_q[1];
            end
            if (mem_en) begin
                vld[1]  <= vld[0];
                rd_q[1] <= rd_q[0];
            end
            if (ex_en) begin
                vld[0]  <= id_wr & ~ex_flush;
                rd_q[0] <= id_rd;
            end
        end
    end

`ifdef HAZARD_FWD_EN
    // Load flag and operand sources of the instruction now in EX, needed to
    // steer the forwarding muxes. A bubble carries x0 sources, which never match.
    logic       ex_ld;
    logic [4:0] ex_src1, ex_src2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_ld   <= 1'b0;
            ex_src1 <= '0;
            ex_src2 <= '0;
        end else if (ex_en) begin
            ex_ld   <= id_load & ~ex_flush;
            ex_src1 <= ex_flush ? 5'd0 : rs1;
            ex_src2 <= ex_flush ? 5'd0 : rs2;
        end
    end

    always_comb begin
        for (int k = 1; k < 3; k++) begin
            ex_match_a[k-1] = vld[k] && (rd_q[k] == ex_src1);
            ex_match_b[k-1] = vld[k] && (rd_q[k] == ex_src2);
        end
    end
`endif

    // A valid slot never holds x0, so a source forced to 0 can never match.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            match_a[k] = vld[k] && (rd_q[k] == rs1);
            match_b[k] = vld[k] && (rd_q[k] == rs2);
        end
`ifdef HAZARD_FWD_EN
        // Results past EX are forwarded; only a load still in EX must stall.
        match_a[0] = match_a[0] & ex_ld;
        match_b[0] = match_b[0] & ex_ld;
`endif
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller beside the ID stage.
// Detects RAW hazards against in-flight rd's, freezes on data-memory wait,
// bubbles on EX redirect, and keeps saturating stall/flush counters.
//   clk, reset_n          clock, async active-low reset
//   id_*                  decoder fields of the instruction in ID
//   ex_redirect           taken branch / JAL / JALR resolved in EX
//   mem_ready             data memory completes this cycle (0 = wait)
//   pc_en .. mem_wb_en    per-stage register enables
//   if_id_flush           load NOP into IF/ID
//   id_ex_flush           load bubble into ID/EX
//   stall_count           hazard + memory-wait cycles, saturating
//   flush_count           redirect events, saturating
//   fwd_a_sel, fwd_b_sel  (HAZARD_FWD_EN only) EX operand mux selects
//   state                 registered controller state, for debug
// Build macro: HAZARD_FWD_EN (forwarding datapath; only load-use stalls).
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_redirect,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
`ifdef HAZARD_FWD_EN
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
`endif
    output pipe_state_e      state
);

    logic [4:0]  src1, src2;
    logic        id_wr;
    logic [2:0]  match_a, match_b;
    logic        hazard;
    logic        stall_inc, flush_inc;
    pipe_state_e state_nxt;

    assign src1  = (id_valid && reads_rs1(id_opcode)) ? id_rs1 : 5'd0;
    assign src2  = (id_valid && reads_rs2(id_opcode)) ? id_rs2 : 5'd0;
    assign id_wr = id_valid && writes_rd(id_opcode) && (id_rd != 5'd0);

`ifdef HAZARD_FWD_EN
    logic       id_load;
    logic [1:0] ex_match_a, ex_match_b;
    assign id_load = id_valid && (id_opcode == OP_LOAD);
`endif

    hazard_scoreboard u_sb (
        .clk        (clk),
        .reset_n    (reset_n),
        .ex_en      (id_ex_en),
        .mem_en     (ex_mem_en),
        .wb_en      (mem_wb_en),
        .ex_flush   (id_ex_flush),
        .id_wr      (id_wr),
        .id_rd      (id_rd),
`ifdef HAZARD_FWD_EN
        .id_load    (id_load),
        .ex_match_a (ex_match_a),
        .ex_match_b (ex_match_b),
`endif
        .rs1        (src1),
        .rs2        (src2),
        .match_a    (match_a),
        .match_b    (match_b)
    );

    assign hazard = |{match_a, match_b};

    // Priority: reset > memory wait > redirect > hazard > run.
    // Reset forces the idle outputs so no partial stall/flush leaks out.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state_nxt   = ST_RUN;
        if (!reset_n) begin
            state_nxt = ST_RUN;
        end else if (!mem_ready) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            stall_inc = 1'b1;
            state_nxt = ST_MEM_WAIT;
        end else if (ex_redirect) begin
            // The dependent instruction is flushed anyway, so hazards are moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (hazard) begin
            // Hold PC and IF/ID, push a bubble into EX, let older work drain.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
            state_nxt   = ST_HAZ_STALL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= state_nxt;
            if (stall_inc && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (flush_inc && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

`ifdef HAZARD_FWD_EN
    // Younger result (EX/MEM) wins over MEM/WB.
    assign fwd_a_sel = ex_match_a[0] ? FWD_EX_MEM : ex_match_a[1] ? FWD_MEM_WB : FWD_RF;
    assign fwd_b_sel = ex_match_b[0] ? FWD_EX_MEM : ex_match_b[1] ? FWD_MEM_WB : FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import riscv_pipe_pkg::*;

    localparam int CNT_W = 16;
    localparam int SMAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_FWD_EN
    localparam int EXP_ALU_USE  = 0;
    localparam int EXP_LOAD_USE = 1;
    localparam int EXP_MEMWAIT  = 5;
`else
    localparam int EXP_ALU_USE  = 3;
    localparam int EXP_LOAD_USE = 3;
    localparam int EXP_MEMWAIT  = 7;
`endif

    logic             clk, reset_n;
    logic             id_valid, ex_redirect, mem_ready;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rd, id_rs1, id_rs2;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush;
    logic [CNT_W-1:0] stall_count, flush_count;
    pipe_state_e      state;
`ifdef HAZARD_FWD_EN
    logic [1:0]       fwd_a_sel, fwd_b_sel;
`endif

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_redirect(ex_redirect),
        .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .stall_count(stall_count), .flush_count(flush_count),
`ifdef HAZARD_FWD_EN
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`endif
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit v; bit [6:0] op; bit [4:0] rd, rs1, rs2; } ins_t;
    // in-flight instruction: writes rd (v), is a load, its read sources (0 = none)
    typedef struct { bit v; bit [4:0] rd; bit ld; bit [4:0] s1, s2; } ent_t;

    ent_t        pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
    ent_t        empty_e;
    int          m_stall, m_flush;
    pipe_state_e m_state;
    bit e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_iff, e_idf;
    // DUT values sampled in the last cycle
    bit s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_iff, s_idf;
    int s_scnt, s_fcnt, s_fa, s_fb;

    function automatic bit op_r1(bit [6:0] op);
        return op inside {OP_R, OP_STORE, OP_BRANCH, OP_IMM, OP_LOAD, OP_JALR};
    endfunction
    function automatic bit op_r2(bit [6:0] op);
        return op inside {OP_R, OP_STORE, OP_BRANCH};
    endfunction
    function automatic bit op_w(bit [6:0] op);
        return op inside {OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    function automatic ent_t mk_ent(ins_t i);
        ent_t e;
        e.v  = i.v && op_w(i.op) && (i.rd != 0);
        e.rd = i.rd;
        e.ld = i.v && (i.op == OP_LOAD);
        e.s1 = (i.v && op_r1(i.op)) ? i.rs1 : 5'd0;
        e.s2 = (i.v && op_r2(i.op)) ? i.rs2 : 5'd0;
        return e;
    endfunction

    function automatic int fsel(bit [4:0] s);
        if (s != 0 && pipe[1].v && pipe[1].rd == s) return 2;
        if (s != 0 && pipe[2].v && pipe[2].rd == s) return 1;
        return 0;
    endfunction

    function automatic ins_t mk(bit [6:0] op, bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2);
        ins_t i;
        i.v = 1'b1; i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        bit [6:0] ops [10];
        ins_t i;
        ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b1111111};
        i.v   = ($urandom_range(0, 9) != 0);
        i.op  = ops[$urandom_range(0, 9)];
        i.rd  = 5'($urandom_range(0, 7));
        i.rs1 = 5'($urandom_range(0, 7));
        i.rs2 = 5'($urandom_range(0, 7));
        return i;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = empty_e;
        m_stall = 0; m_flush = 0; m_state = ST_RUN;
    endtask

    // One clock: drive at negedge, compare just after, advance model at posedge.
    task automatic cyc(input ins_t i, input bit redir, input bit mrdy);
        ent_t        e;
        bit          hz, sinc, finc;
        bit [4:0]    r;
        pipe_state_e nst;
        @(negedge clk);
        id_valid = i.v; id_opcode = i.op; id_rd = i.rd; id_rs1 = i.rs1; id_rs2 = i.rs2;
        ex_redirect = redir; mem_ready = mrdy;
        #1;
        e  = mk_ent(i);
        hz = 0;
        for (int s = 0; s < 2; s++) begin
            r = (s == 0) ? e.s1 : e.s2;
            if (r != 0)
                for (int k = 0; k < 3; k++) begin
`ifdef HAZARD_FWD_EN
                    if (k == 0 && pipe[0].v && pipe[0].ld && pipe[0].rd == r) hz = 1;
`else
                    if (pipe[k].v && pipe[k].rd == r) hz = 1;
`endif
                end
        end
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
        {e_iff, e_idf, sinc, finc} = 4'b0000;
        nst = ST_RUN;
        if (!mrdy) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
            sinc = 1; nst = ST_MEM_WAIT;
        end else if (redir) begin
            e_iff = 1; e_idf = 1; finc = 1;
        end else if (hz) begin
            e_pc = 0; e_ifid = 0; e_idf = 1; sinc = 1; nst = ST_HAZ_STALL;
        end
        s_pc = pc_en; s_ifid = if_id_en; s_idex = id_ex_en; s_exmem = ex_mem_en;
        s_memwb = mem_wb_en; s_iff = if_id_flush; s_idf = id_ex_flush;
        s_scnt = int'(stall_count); s_fcnt = int'(flush_count);
        chk("pc_en",       32'(pc_en),       32'(e_pc));
        chk("if_id_en",    32'(if_id_en),    32'(e_ifid));
        chk("id_ex_en",    32'(id_ex_en),    32'(e_idex));
        chk("ex_mem_en",   32'(ex_mem_en),   32'(e_exmem));
        chk("mem_wb_en",   32'(mem_wb_en),   32'(e_memwb));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_iff));
        chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        chk("flush_count", 32'(flush_count), 32'(m_flush));
        chk("state",       32'(state),       32'(m_state));
`ifdef HAZARD_FWD_EN
        s_fa = int'(fwd_a_sel); s_fb = int'(fwd_b_sel);
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(fsel(pipe[0].s1)));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(fsel(pipe[0].s2)));
`else
        s_fa = 0; s_fb = 0;
`endif
        @(posedge clk);
        if (e_memwb) pipe[2] = pipe[1];
        if (e_exmem) pipe[1] = pipe[0];
        if (e_idex)  pipe[0] = e_idf ? empty_e : e;
        if (sinc && m_stall < SMAX) m_stall++;
        if (finc && m_flush < SMAX) m_flush++;
        m_state = nst;
    endtask

    ins_t nop;

    // Issue one instruction, holding it while the DUT stalls; count DUT stall cycles.
    task automatic run_ins(input ins_t i, output int stalls);
        stalls = 0;
        for (int n = 0; n < 8; n++) begin
            cyc(i, 1'b0, 1'b1);
            if (s_pc) break;
            stalls++;
        end
    endtask

    task automatic drain();
        repeat (4) cyc(nop, 1'b0, 1'b1);
    endtask

    int   st, base;
    ins_t cur;

    initial begin
        nop = '{default: 0};
        model_reset();
        // reset asserted with wait and redirect both requested
        reset_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        ex_redirect = 1'b1; mem_ready = 1'b0;
        #3;
        chk("rst_enables", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'h1f);
        chk("rst_flushes", 32'({if_id_flush, id_ex_flush}), 32'h0);
        chk("rst_stall_cnt", 32'(stall_count), 32'h0);
        chk("rst_flush_cnt", 32'(flush_count), 32'h0);
        chk("rst_state", 32'(state), 32'(ST_RUN));
        @(negedge clk);
        reset_n = 1'b1; ex_redirect = 1'b0; mem_ready = 1'b1;

        // ADDI x3,x0,1 ; SUB x4,x3,x3
        run_ins(mk(OP_IMM, 5'd3, 5'd0, 5'd0), st);
        run_ins(mk(OP_R, 5'd4, 5'd3, 5'd3), st);
        chk("alu_use_stalls", 32'(st), 32'(EXP_ALU_USE));
        cyc(nop, 1'b0, 1'b1);
        chk("alu_use_stall_cnt", 32'(s_scnt), 32'(EXP_ALU_USE));
`ifdef HAZARD_FWD_EN
        chk("alu_use_fwd_a", 32'(s_fa), 32'd2);
        chk("alu_use_fwd_b", 32'(s_fb), 32'd2);
`endif
        drain();

        // LW x5,0(x1) ; ADD x6,x5,x2
        run_ins(mk(OP_LOAD, 5'd5, 5'd1, 5'd0), st);
        run_ins(mk(OP_R, 5'd6, 5'd5, 5'd2), st);
        chk("load_use_stalls", 32'(st), 32'(EXP_LOAD_USE));
        cyc(nop, 1'b0, 1'b1);
`ifdef HAZARD_FWD_EN
        chk("load_use_fwd_a", 32'(s_fa), 32'd1);
        chk("load_use_fwd_b", 32'(s_fb), 32'd0);
`endif
        drain();

        // ADDI x0,x0,5 ; ADD x7,x0,x0
        run_ins(mk(OP_IMM, 5'd0, 5'd0, 5'd0), st);
        run_ins(mk(OP_R, 5'd7, 5'd0, 5'd0), st);
        chk("x0_stalls", 32'(st), 32'd0);
        drain();

        // load-use coinciding with redirect
        base = s_scnt;
        cyc(mk(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b1);
        cyc(mk(OP_R, 5'd6, 5'd5, 5'd2), 1'b1, 1'b1);
        chk("redir_pc_en", 32'(s_pc), 32'd1);
        chk("redir_flushes", 32'({s_iff, s_idf}), 32'h3);
        cyc(nop, 1'b0, 1'b1);
        chk("redir_flush_cnt", 32'(s_fcnt), 32'd1);
        chk("redir_no_stall", 32'(s_scnt - base), 32'd0);
        drain();

        // memory wait landing on a load-use hazard
        cyc(mk(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b1);
        base = s_scnt;
        repeat (4) begin
            cyc(mk(OP_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b0);
            chk("memwait_enables", 32'({s_pc, s_ifid, s_idex, s_exmem, s_memwb}), 32'h0);
        end
        run_ins(mk(OP_R, 5'd6, 5'd5, 5'd2), st);
        chk("memwait_resume_stalls", 32'(st), 32'(EXP_LOAD_USE));
        cyc(nop, 1'b0, 1'b1);
        chk("memwait_stall_total", 32'(s_scnt - base), 32'(EXP_MEMWAIT));
        drain();

        // asynchronous reset in the middle of a hazard stall
        cyc(mk(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b1);
        cyc(mk(OP_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_enables", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'h1f);
        chk("midrst_flushes", 32'({if_id_flush, id_ex_flush}), 32'h0);
        chk("midrst_stall_cnt", 32'(stall_count), 32'h0);
        chk("midrst_flush_cnt", 32'(flush_count), 32'h0);
        chk("midrst_state", 32'(state), 32'(ST_RUN));
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        cyc(mk(OP_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b1);
        chk("midrst_sb_empty", 32'(s_pc), 32'd1);
        drain();

        // random traffic with a front end that honours hold and flush
        cur = rnd_ins();
        repeat (1500) begin
            cyc(cur, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) != 0));
            if (e_iff)       cur = nop;
            else if (e_ifid) cur = rnd_ins();
        end

        // stall counter saturation
        repeat (SMAX + 6) cyc(nop, 1'b0, 1'b0);
        #1;
        chk("stall_cnt_sat", 32'(stall_count), 32'(SMAX));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
